ff_serial_tx: RTL and testbench
===============================

// Module: ff_serial_tx
// PURPOSE
//   Parallel-in / serial-out transmitter for the flip-flop pipeline family.
//   Accepts a WIDTH-bit word over a valid/ready handshake, then shifts it
//   out LSB-first, one bit per clk, with a frame strobe and last-bit pulse.
//   Drives single-bit links that feed downstream delay/sync register chains.
// PARAMETERS
//   WIDTH  4  data word width in bits; legal range 2..32
// PORTS
//   clk      input   1      sole clock; all state updates on posedge clk
//   rst      input   1      synchronous reset, active-high
//   data_i   input   WIDTH  parallel word to transmit
//   valid_i  input   1      data_i is valid this cycle
//   ready_o  output  1      block can accept a word this cycle
//   ser_o    output  1      serial data bit, LSB first
//   frame_o  output  1      high on every cycle that ser_o carries a frame bit
//   done_o   output  1      one-cycle pulse coincident with the final frame bit
// BEHAVIOUR
//   - Single clock (clk); reset synchronous, active-high (rst), sampled at posedge.
//   - Reset values: ready_o=1, ser_o=0, frame_o=0, done_o=0, state=IDLE, count=0.
//   - FLEN = WIDTH (WIDTH+1 with parity); count width $clog2(FLEN+1).
//   - States: IDLE, SHIFT.
//   - Accept = valid_i && ready_o at posedge; word captured into shift reg.
//   - ready_o = (state==IDLE) || (state==SHIFT && count==FLEN-1) (combinational
//     from registered state; enables gapless back-to-back frames).
//   - IDLE: ser_o=0, frame_o=0. On accept -> SHIFT, count=0.
//   - Latency: bit0 of accepted word appears on ser_o the cycle after accept.
//   - SHIFT: ser_o=shreg[0], frame_o=1; each cycle shreg>>=1, count++.
//   - count==FLEN-1: done_o=1 that cycle. Next cycle: if accept occurred
//     -> stay SHIFT, count=0, new word's bit0 on ser_o (no idle gap);
//     else -> IDLE.
//   - valid_i while ready_o=0 is ignored; upstream must hold word until accept.
//   - data_i changes after accept have no effect on the frame in flight.
//   - rst mid-frame: next cycle all outputs at reset values; partial word
//     discarded; no done_o pulse emitted for it.
//   - rst and valid_i same cycle: rst wins, word not accepted.
// CONFIGURATION
//   FF_SERIAL_TX_PARITY_EN
//   - Defined: after the WIDTH data bits, one extra frame bit = even parity
//     (XOR of all data bits) is sent; FLEN=WIDTH+1; done_o on parity bit.
//   - Undefined: FLEN=WIDTH; no parity bit; done_o on data MSB.
// TESTING
//   1. WIDTH=4, data_i=4'b1011, valid_i 1 cycle -> ser_o 1,1,0,1 on cycles
//      +1..+4; frame_o high 4 cycles; done_o on +4 only; ready_o low +1..+3.
//   2. Back-to-back 4'hA then 4'h5, valid_i held -> 8 contiguous frame_o
//      cycles, ser_o 0,1,0,1,1,0,1,0; done_o on cycles +4 and +8.
//   3. valid_i pulsed with 4'hF at frame bit 1 of 4'h0 -> ignored; ser_o
//      stays 0 for all 4 bits; only one done_o pulse; ready_o back to 1.
//   4. rst asserted during bit 2 of 4'hF -> next cycle ser_o=0, frame_o=0,
//      ready_o=1, done_o=0; no further frame bits.
//   5. PARITY_EN defined, data_i=4'b0111 -> ser_o 1,1,1,0,1; frame_o high
//      5 cycles; done_o on 5th bit. With 4'b0101 -> parity bit 0.
//   6. data_i toggled every cycle after accept of 4'hC -> ser_o 0,0,1,1
//      unaffected.

Source files
------------

// File: rtl/ff_serial_tx.sv
// ff_serial_tx: LSB-first parallel-to-serial transmitter with valid/ready intake, frame strobe and last-bit pulse.
// Define FF_SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module ff_serial_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             frame_o,
    output logic             done_o
);
`ifdef FF_SERIAL_TX_PARITY_EN
    localparam int FLEN = WIDTH + 1;
    logic [FLEN-1:0] w_frame;
    assign w_frame = {^data_i, data_i};
`else
    localparam int FLEN = WIDTH;
    logic [FLEN-1:0] w_frame;
    assign w_frame = data_i;
`endif
    localparam int CW = $clog2(FLEN + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t          r_state, w_next;
    logic [CW-1:0]   r_count;
    logic [FLEN-1:0] r_shreg;
    logic            w_last, w_accept;
    assign w_last   = (r_state == SHIFT) && (r_count == CW'(FLEN - 1));
    assign w_accept = valid_i && ready_o;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_shreg <= w_frame;
                r_count <= '0;
            end else if (r_state == SHIFT) begin
                r_shreg <= r_shreg >> 1;
                r_count <= r_count + CW'(1);
            end
        end
    end
    // A new word accepted on the last bit keeps SHIFT running with no idle gap
    always_comb begin
        w_next = w_accept ? SHIFT : (w_last ? IDLE : r_state);
    end
    always_comb begin
        ready_o = (r_state == IDLE) || w_last;
        frame_o = (r_state == SHIFT);
        ser_o   = (r_state == SHIFT) && r_shreg[0];
        done_o  = w_last;
    end
endmodule

// File: tb/tb_ff_serial_tx.sv
// tb_ff_serial_tx: scoreboard bench; accepted words expand into a queue of expected frame bits popped by a monitor.
// Build with FF_SERIAL_TX_PARITY_EN defined to check the parity variant.
module tb_ff_serial_tx;
    localparam int WIDTH = 4;
    typedef struct {
        logic b;
        logic last;
    } exp_t;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o, ser_o, frame_o, done_o;
    exp_t             q[$];
    int               checks = 0;
    int               failures = 0;
    ff_serial_tx #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .ser_o(ser_o), .frame_o(frame_o), .done_o(done_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", n, $time, a, e);
        end
    endtask
    // Expected bits of one frame: data LSB first, optionally followed by even parity
    task automatic push_word(input logic [WIDTH-1:0] d);
        logic bits[$];
        for (int i = 0; i < WIDTH; i++) bits.push_back(d[i]);
`ifdef FF_SERIAL_TX_PARITY_EN
        bits.push_back(^d);
`endif
        foreach (bits[i]) q.push_back('{b: bits[i], last: (i == bits.size() - 1)});
    endtask
    // One input cycle; the block is free to accept only when no frame bits remain after the current one
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, output logic acc);
        @(negedge clk);
        rst = r;
        valid_i = v;
        data_i = d;
        acc = 1'b0;
        if (r) q.delete();
        else if (v && q.size() == 0) begin
            push_word(d);
            acc = 1'b1;
        end
    endtask
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("frame", frame_o, 1'b1);
            chk("ser", ser_o, e.b);
            chk("done", done_o, e.last);
        end else begin
            chk("frame_idle", frame_o, 1'b0);
            chk("ser_idle", ser_o, 1'b0);
            chk("done_idle", done_o, 1'b0);
        end
        chk("ready", ready_o, q.size() == 0);
    end
    initial begin
        logic acc;
        repeat (3) cyc(1'b1, 4'hF, 1'b1, acc);
        cyc(1'b0, 4'h0, 1'b0, acc);
        cyc(1'b1, 4'b1011, 1'b0, acc);
        repeat (6) cyc(1'b0, 4'h0, 1'b0, acc);
        cyc(1'b1, 4'hA, 1'b0, acc);
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) cyc(1'b1, 4'h5, 1'b0, acc);
        repeat (6) cyc(1'b0, 4'h0, 1'b0, acc);
        cyc(1'b1, 4'h0, 1'b0, acc);
        cyc(1'b0, 4'h0, 1'b0, acc);
        cyc(1'b1, 4'hF, 1'b0, acc);
        repeat (5) cyc(1'b0, 4'h0, 1'b0, acc);
        cyc(1'b1, 4'hF, 1'b0, acc);
        repeat (2) cyc(1'b0, 4'h0, 1'b0, acc);
        cyc(1'b1, 4'h3, 1'b1, acc);
        repeat (4) cyc(1'b0, 4'h0, 1'b0, acc);
        cyc(1'b1, 4'hC, 1'b0, acc);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'(i * 5 + 3), 1'b0, acc);
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 2) != 0), 4'($urandom), 1'($urandom_range(0, 63) == 0), acc);
        repeat (10) cyc(1'b0, 4'h0, 1'b0, acc);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending bits expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
